// File: rtl/window_filter_3x3.sv
// rtl/window_filter_3x3.sv - streaming 3x3 convolution over one strip of memory windows
// Issues NPIX read strobes, then a 3-stage multiply / sum / round-shift-clamp pipeline feeds the write port.
module window_filter_3x3 #(
    parameter int                NPIX  = 8192,
    parameter logic signed [4:0] K0    = 5'sd1,
    parameter logic signed [4:0] K1    = 5'sd2,
    parameter logic signed [4:0] K2    = 5'sd1,
    parameter logic signed [4:0] K3    = 5'sd2,
    parameter logic signed [4:0] K4    = 5'sd4,
    parameter logic signed [4:0] K5    = 5'sd2,
    parameter logic signed [4:0] K6    = 5'sd1,
    parameter logic signed [4:0] K7    = 5'sd2,
    parameter logic signed [4:0] K8    = 5'sd1,
    parameter int                SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pixelr1,
    input  logic [7:0] pixelr2,
    input  logic [7:0] pixelr3,
    input  logic [7:0] pixelr4,
    input  logic [7:0] pixelr5,
    input  logic [7:0] pixelr6,
    input  logic [7:0] pixelr7,
    input  logic [7:0] pixelr8,
    input  logic [7:0] pixelr9,
    output logic       rd,
    output logic [7:0] pixelw,
    output logic       wr,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W = 14;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NPIX - 1);
    localparam int                RND   = (1 << SHIFT) >> 1;
    localparam logic signed [4:0] COEF [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         vld_q, vld_d;
    logic [7:0]         pix [9];
    logic signed [13:0] prod_q [9];
    logic signed [13:0] prod_d [9];
    logic signed [17:0] sum_q, sum_d;
    logic signed [17:0] acc;
    logic signed [18:0] rnd;
    logic signed [18:0] shf;
    logic [7:0]         pixelw_q, pixelw_d;

    assign pix[0] = pixelr1;
    assign pix[1] = pixelr2;
    assign pix[2] = pixelr3;
    assign pix[3] = pixelr4;
    assign pix[4] = pixelr5;
    assign pix[5] = pixelr6;
    assign pix[6] = pixelr7;
    assign pix[7] = pixelr8;
    assign pix[8] = pixelr9;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                rd    = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // bit 3 is the final write itself, so only the upstream stages must be empty
                if (vld_q[2:0] == 3'b000) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign vld_d = {vld_q[2:0], rd};

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = vld_q[0] ? 14'($signed({1'b0, pix[k]})) * 14'(COEF[k]) : prod_q[k];
        end

        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + 18'(prod_q[k]);
        end
        sum_d = vld_q[1] ? acc : sum_q;

        // one guard bit keeps the rounding add from wrapping the sign
        rnd = {sum_q[17], sum_q} + 19'(RND);
        shf = rnd >>> SHIFT;

        pixelw_d = pixelw_q;
        if (vld_q[2]) begin
            if (shf < 0) begin
                pixelw_d = 8'd0;
            end else if (shf > 19'sd255) begin
                pixelw_d = 8'd255;
            end else begin
                pixelw_d = shf[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vld_q    <= '0;
            sum_q    <= '0;
            pixelw_q <= '0;
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            sum_q    <= sum_d;
            pixelw_q <= pixelw_d;
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

    assign pixelw = pixelw_q;
    assign wr     = vld_q[3];

endmodule
